store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Sub-word store engine for the MIPS datapath memory stage. It is the write-side counterpart of the load/immediate extension path: instead of widening a narrow value to 32 bits, it narrows a 32-bit register value to a byte or halfword and inserts it into the right lane of a word-only data memory. It does this with a read-modify-write sequence and stalls the pipeline through `Busy` until the store completes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-address width of the data memory. The memory depth is 2^ADDR_WIDTH words.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `StoreReq` in 1: store request. Sampled only in IDLE.
- `StoreSize` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `StoreAddr` in 32: byte address. Bits above `ADDR_WIDTH+1` are ignored and never fault.
- `StoreData` in 32: register value. Only the low 8 or 16 bits are used for byte and halfword stores.
- `Busy` out 1: pipeline stall. High in every state except IDLE.
- `Done` out 1: one-cycle pulse when the store completes.
- `Misaligned` out 1: one-cycle pulse when a request is rejected for misalignment.
- `MemAddr` out ADDR_WIDTH: word address, equal to latched `StoreAddr[ADDR_WIDTH+1:2]`.
- `MemRead` out 1: memory read strobe.
- `MemReadData` in 32: memory read data. Valid the cycle after `MemRead` (synchronous read, latency 1).
- `MemWrite` out 1: memory write strobe. Memory commits on the clock edge ending the cycle in which `MemWrite` is high.
- `MemWriteData` out 32: word to write.

## Operation
- Byte order is little-endian.
  - Byte lane k = `StoreAddr[1:0]` occupies bits [8k+7:8k].
  - Halfword lane h = `StoreAddr[1]` occupies bits [16h+15:16h].
- Alignment rules:
  - Halfword with `StoreAddr[0]=1` is misaligned.
  - Word (size 10 or 11) with `StoreAddr[1:0]!=0` is misaligned.
  - Bytes are never misaligned.
- Request acceptance: in IDLE with `StoreReq=1`, the block latches address, data and size, then branches:
  - misaligned → ERR
  - word → WRITE (no read)
  - byte or halfword → READ
- FSM states and transitions:
  - IDLE: `Busy=0`. Waits for `StoreReq`.
  - ERR: `Misaligned=1`, `Busy=1`. No memory access. Next state is IDLE.
  - READ: `MemRead=1`, `MemAddr` driven. Next state is MERGE.
  - MERGE: the merged word register loads `MemReadData` with only the target lane replaced by `StoreData[7:0]` or `StoreData[15:0]`; all other bits are preserved. Next state is WRITE.
  - WRITE: `MemWrite=1`, `MemWriteData` = merged register (word stores: latched `StoreData`). Next state is DONE.
  - DONE: `Done=1`, `Busy=1`. Next state is IDLE unconditionally.
- Outputs are Moore outputs, decoded from state and registers. `MemRead` and `MemWrite` are never high in the same cycle.
- `StoreReq` is ignored outside IDLE. The requester holds the request or reissues it after `Busy` falls.
- Reset:
  - Values: state IDLE; `Busy`, `Done`, `Misaligned`, `MemRead`, `MemWrite` = 0; `MemAddr` = 0; `MemWriteData` = 0; all latches 0.
  - Reset mid-operation returns the block to IDLE immediately, asynchronously, and the in-flight store is abandoned. Memory is unchanged unless a WRITE-cycle clock edge already occurred.

## Timing
The request is accepted on the edge ending cycle T.
- Word store: WRITE in T+1, DONE in T+2, IDLE in T+3.
- Byte or halfword store: READ in T+1, MERGE in T+2, WRITE in T+3, DONE in T+4, IDLE in T+5.
- Misaligned request: ERR in T+1, IDLE in T+2.
- Back-to-back stores: earliest next acceptance is the first IDLE cycle.
- Throughput: one word store per 3 cycles, one sub-word store per 5 cycles.
- `MemAddr` is stable from the first cycle after acceptance through DONE.

## Test plan
1. **Reset:** assert `reset` asynchronously mid-cycle → every output reads 0 immediately. Deassert → IDLE, `Busy=0`.
2. **Word store:** `StoreSize=10`, `StoreAddr=0x10`, `StoreData=0xDEADBEEF` → T+1: `MemWrite=1`, `MemAddr=4`, `MemWriteData=0xDEADBEEF`, `MemRead` never high. T+2: `Done=1`. T+3: `Busy=0`.
3. **Byte store:** memory word 4 = 0x11223344; `StoreSize=00`, `StoreAddr=0x13`, `StoreData=0xFFFFFFAA` → T+1: `MemRead=1`, `MemAddr=4`. T+3: `MemWriteData=0xAA223344`. T+4: `Done=1`. Repeat at 0x10 → 0x112233AA.
4. **Halfword store:** memory word 4 = 0x11223344; `StoreSize=01`, `StoreAddr=0x12`, `StoreData=0x1234CAFE` → write data 0xCAFE3344. At `StoreAddr=0x10` → 0x1122CAFE.
5. **Misaligned:** halfword at 0x11, then word at 0x12 → each gives `Misaligned=1` in T+1, no `MemRead` or `MemWrite`, and memory unchanged. The next aligned store completes normally.
6. **Reset mid-store / request while busy:** assert `reset` during MERGE of a byte store → no `MemWrite`, memory unchanged, and a following store succeeds. Pulse `StoreReq` during READ → ignored, and exactly one `Done` is seen.

Source files
------------

// File: rtl/store_merge_unit.sv
// Sub-word store engine: narrows a register value to a byte or halfword and
// inserts it into a word-only data memory by read-modify-write, stalling via Busy.
module store_merge_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StoreReq,
    input  logic [1:0]            StoreSize,
    input  logic [31:0]           StoreAddr,
    input  logic [31:0]           StoreData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Misaligned,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    input  logic [31:0]           MemReadData,
    output logic                  MemWrite,
    output logic [31:0]           MemWriteData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              size_q, size_d;
    logic [15:0]             data_q, data_d;
    logic [31:0]             merged_q, merged_d;

    logic                    req_misaligned;
    logic [3:0]              lane_sel;
    logic [31:0]             merge_word;

    // Upper address bits lie outside the memory and are deliberately ignored.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^StoreAddr[31:ADDR_WIDTH+2];

    assign req_misaligned = ((StoreSize == 2'b01) && StoreAddr[0]) ||
                            (StoreSize[1] && (StoreAddr[1:0] != 2'b00));

    // Per-byte lane select and merge; halfword stores feed both bytes of the pair.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = size_q[0] ? (lane_q[1] == LANE[1])
                                            : (lane_q == LANE);
            assign merge_word[8*gi +: 8] =
                !lane_sel[gi] ? MemReadData[8*gi +: 8] :
                size_q[0]     ? data_q[8*(gi%2) +: 8]  :
                                data_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lane_d   = lane_q;
        size_d   = size_q;
        data_d   = data_q;
        merged_d = merged_q;
        case (state_q)
            S_IDLE: begin
                if (StoreReq) begin
                    addr_d = StoreAddr[ADDR_WIDTH+1:2];
                    lane_d = StoreAddr[1:0];
                    size_d = StoreSize;
                    data_d = StoreData[15:0];
                    if (req_misaligned) begin
                        state_d = S_ERR;
                    end else if (StoreSize[1]) begin
                        merged_d = StoreData;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_READ:  state_d = S_MERGE;
            S_MERGE: begin
                merged_d = merge_word;
                state_d  = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            data_q   <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            data_q   <= data_d;
            merged_q <= merged_d;
        end
    end

    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign Misaligned   = (state_q == S_ERR);
    assign MemRead      = (state_q == S_READ);
    assign MemWrite     = (state_q == S_WRITE);
    assign MemAddr      = addr_q;
    assign MemWriteData = merged_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed spec cases plus random stores checked
// against an arithmetic byte-lane reference memory.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StoreReq = 1'b0;
    logic [1:0]  StoreSize = 2'b00;
    logic [31:0] StoreAddr = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        Busy, Done, Misaligned, MemRead, MemWrite;
    logic [7:0]  MemAddr;
    logic [31:0] MemReadData, MemWriteData;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;
    logic [31:0] rd_q;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .StoreReq(StoreReq), .StoreSize(StoreSize),
        .StoreAddr(StoreAddr), .StoreData(StoreData), .Busy(Busy), .Done(Done),
        .Misaligned(Misaligned), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemReadData(MemReadData), .MemWrite(MemWrite), .MemWriteData(MemWriteData)
    );

    // Word-only memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (MemRead) rd_q <= mem[MemAddr];
        if (MemWrite) mem[MemAddr] <= MemWriteData;
        if (pre_we) mem[pre_addr] <= pre_data;
    end
    assign MemReadData = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        int sh;
        logic [31:0] m;
        if (sz >= 2'd2) return d;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'hFF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            m  = 32'hFFFF << sh;
        end
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic preload(input logic [7:0] wa, input logic [31:0] val);
        pre_we = 1'b1; pre_addr = wa; pre_data = val;
        tick();
        pre_we = 1'b0;
        ref_mem[wa] = val;
    endtask

    // Issues one store (already in IDLE) and checks every cycle until IDLE.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input bit poke);
        logic [7:0]  wa;
        logic [31:0] exp;
        wa  = a[9:2];
        exp = ref_merge(ref_mem[wa], sz, a, d);
        StoreReq = 1'b1; StoreSize = sz; StoreAddr = a; StoreData = d;
        tick();
        StoreReq = 1'b0;
        if (ref_misaligned(sz, a)) begin
            chk("err_mis", 32'(Misaligned), 1);
            chk("err_busy", 32'(Busy), 1);
            chk("err_rw", 32'({MemRead, MemWrite}), 0);
            tick();
            chk("err_idle", 32'({Busy, Misaligned}), 0);
            chk("err_mem", mem[wa], ref_mem[wa]);
        end else if (sz[1]) begin
            chk("w_write", 32'({MemRead, MemWrite}), 1);
            chk("w_addr", 32'(MemAddr), 32'(wa));
            chk("w_data", MemWriteData, exp);
            tick();
            chk("w_done", 32'({Done, MemWrite, Busy}), 32'b101);
            tick();
            chk("w_idle", 32'({Busy, Done}), 0);
            ref_mem[wa] = exp;
            chk("w_mem", mem[wa], exp);
        end else begin
            chk("s_read", 32'({MemRead, MemWrite}), 32'b10);
            chk("s_raddr", 32'(MemAddr), 32'(wa));
            if (poke) begin
                StoreReq = 1'b1; StoreSize = 2'b10; StoreAddr = 32'h20; StoreData = $urandom;
            end
            tick();
            StoreReq = 1'b0;
            chk("s_merge", 32'({MemRead, MemWrite, Busy}), 1);
            tick();
            chk("s_write", 32'({MemRead, MemWrite}), 1);
            chk("s_waddr", 32'(MemAddr), 32'(wa));
            chk("s_data", MemWriteData, exp);
            tick();
            chk("s_done", 32'({Done, MemWrite, Busy}), 32'b101);
            tick();
            chk("s_idle", 32'({Busy, Done}), 0);
            ref_mem[wa] = exp;
            chk("s_mem", mem[wa], exp);
            if (poke) begin
                tick();
                chk("poke_no_restart", 32'({Busy, Done, MemWrite}), 0);
                chk("poke_mem8", mem[8], ref_mem[8]);
            end
        end
    endtask

    initial begin
        logic [1:0]  rsz;
        logic [31:0] ra;

        // Asynchronous reset mid-cycle, before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_outs", 32'({Busy, Done, Misaligned, MemRead, MemWrite}), 0);
        chk("rst_addr", 32'(MemAddr), 0);
        chk("rst_wdata", MemWriteData, 0);
        for (int i = 0; i < 16; i++) preload(8'(i), $urandom);
        reset = 1'b0;
        tick();
        chk("rst_idle", 32'(Busy), 0);

        // Directed cases.
        do_store(2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("dir_word", mem[4], 32'hDEADBEEF);
        preload(8'd4, 32'h11223344);
        do_store(2'b00, 32'h13, 32'hFFFFFFAA, 1'b0);
        chk("dir_byte3", mem[4], 32'hAA223344);
        preload(8'd4, 32'h11223344);
        do_store(2'b00, 32'h10, 32'hFFFFFFAA, 1'b0);
        chk("dir_byte0", mem[4], 32'h112233AA);
        preload(8'd4, 32'h11223344);
        do_store(2'b01, 32'h12, 32'h1234CAFE, 1'b0);
        chk("dir_half1", mem[4], 32'hCAFE3344);
        preload(8'd4, 32'h11223344);
        do_store(2'b01, 32'h10, 32'h1234CAFE, 1'b0);
        chk("dir_half0", mem[4], 32'h1122CAFE);
        do_store(2'b01, 32'h11, 32'h0000BEEF, 1'b0);
        do_store(2'b10, 32'h12, 32'h12345678, 1'b0);
        chk("dir_mis_mem", mem[4], 32'h1122CAFE);
        do_store(2'b11, 32'h14, 32'h0BADF00D, 1'b0);

        // Reset during MERGE abandons the store with memory untouched.
        StoreReq = 1'b1; StoreSize = 2'b00; StoreAddr = 32'h10; StoreData = 32'h55;
        tick();
        StoreReq = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({Busy, Done, Misaligned, MemRead, MemWrite}), 0);
        chk("mid_rst_addr", 32'(MemAddr), 0);
        chk("mid_rst_wdata", MemWriteData, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_idle", 32'({Busy, MemWrite}), 0);
        chk("mid_rst_mem", mem[4], 32'h1122CAFE);
        do_store(2'b00, 32'h11, 32'h77, 1'b0);
        chk("after_rst", mem[4], 32'h112277FE);

        // Request pulsed during READ must be ignored.
        do_store(2'b00, 32'h1A, $urandom, 1'b1);

        // Random stores; upper address bits are noise the DUT must ignore.
        for (int n = 0; n < 60; n++) begin
            rsz = 2'($urandom_range(0, 3));
            ra  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            do_store(rsz, ra, $urandom, 1'b0);
        end
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
